rocketcpu_param_scheduler: RTL and testbench

Wishbone-slave controller that stages CPU writes to the audio parameter bank in shadow registers and commits them atomically to the live parameter outputs on the next audio sample tick. It sits between the rocketcpu Wishbone bus and the audio datapath. It replaces direct per-word parameter writes, so multi-word parameter sets (filter coefficients, envelope settings) never change mid-sample.

---
 rtl/rocketcpu_audio_pkg.sv | 25 ++
 rtl/rocketcpu_param_bank.sv | 83 ++++++++
 rtl/rocketcpu_param_scheduler.sv | 150 +++++++++++++++
 tb/tb_rocketcpu_param_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocketcpu_audio_pkg.sv
// ---------------------------------------------------------------------------
// rocketcpu_audio_pkg
// Shared definitions for the audio parameter scheduler: register-map offsets
// relative to the scheduler base address, CTRL bit positions and the commit
// FSM state encoding.
// ---------------------------------------------------------------------------
package rocketcpu_audio_pkg;

  // Byte offsets of the register windows, relative to BASE_ADR
  localparam logic [31:0] SHADOW_OFS = 32'h0000_0000;
  localparam logic [31:0] LIVE_OFS   = 32'h0000_0080;
  localparam logic [31:0] CTRL_OFS   = 32'h0000_0100;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0104;

  // CTRL register bit positions
  localparam int COMMIT_BIT = 0;
  localparam int ABORT_BIT  = 1;

  // Commit FSM: IDLE waits for a commit request, ARMED waits for a sample tick
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } schedState_e;

endpackage

// File: rtl/rocketcpu_param_bank.sv
// ---------------------------------------------------------------------------
// rocketcpu_param_bank
// NPARAMS pairs of 32-bit shadow/live registers. The CPU writes the shadow
// side through a byte-enable port; a single copy strobe moves every shadow
// word into the live side at once.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   wrEn_i            shadow write strobe
//   wrIdx_i           shadow word index for writes (out-of-range is ignored)
//   wrData_i/wrSel_i  write data and byte enables
//   copy_i            bulk copy shadow -> live
//   rdIdx_i           word index for both read muxes
//   shadowRdata_o     shadow word at rdIdx_i (0 if out of range)
//   liveRdata_o       live word at rdIdx_i (0 if out of range)
//   params_o          flattened live bank, word k at [32k+31:32k]
// ---------------------------------------------------------------------------
module rocketcpu_param_bank #(
  parameter int NPARAMS = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wrEn_i,
  input  logic [4:0]              wrIdx_i,
  input  logic [31:0]             wrData_i,
  input  logic [3:0]              wrSel_i,
  input  logic                    copy_i,
  input  logic [4:0]              rdIdx_i,
  output logic [31:0]             shadowRdata_o,
  output logic [31:0]             liveRdata_o,
  output logic [32*NPARAMS-1:0]   params_o
);

  logic [31:0] shadow_q [NPARAMS];
  logic [31:0] live_q   [NPARAMS];

  // Shadow and live storage. The copy samples the shadow contents as they
  // stand before this edge, so a shadow write landing on the same edge as a
  // copy only reaches the shadow side and waits for the next commit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NPARAMS; k++) begin
        shadow_q[k] <= '0;
        live_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NPARAMS; k++) begin
        if (copy_i) begin
          live_q[k] <= shadow_q[k];
        end
        if (wrEn_i && (wrIdx_i == 5'(k))) begin
          for (int b = 0; b < 4; b++) begin
            if (wrSel_i[b]) begin
              shadow_q[k][8*b +: 8] <= wrData_i[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Read muxes: an index past the last implemented word matches nothing and
  // so reads back as zero.
  always_comb begin
    shadowRdata_o = '0;
    liveRdata_o   = '0;
    for (int k = 0; k < NPARAMS; k++) begin
      if (rdIdx_i == 5'(k)) begin
        shadowRdata_o = shadow_q[k];
        liveRdata_o   = live_q[k];
      end
    end
  end

  // Flatten the live bank onto the datapath-facing bus
  always_comb begin
    params_o = '0;
    for (int k = 0; k < NPARAMS; k++) begin
      params_o[32*k +: 32] = live_q[k];
    end
  end

endmodule

// File: rtl/rocketcpu_param_scheduler.sv
// ---------------------------------------------------------------------------
// rocketcpu_param_scheduler
// Wishbone slave that stages audio parameter writes in shadow registers and
// commits the whole set to the live outputs on the next audio sample tick,
// so multi-word parameter sets never change in the middle of a sample.
//
// Ports:
//   i_wb_clk, i_wb_rst   clock, asynchronous active-high reset
//   i_wb_adr/dat/sel/we  Wishbone address, write data, byte enables, write
//   i_wb_cyc             cycle/strobe
//   o_wb_rdt, o_wb_ack   registered read data, single-cycle acknowledge
//   i_sample_tick        one-cycle strobe per audio sample
//   o_params             live parameter bank, word k at [32k+31:32k]
//   o_commit_pulse       one cycle high when the live bank is updated
//   o_pending            commit armed, waiting for a tick
// ---------------------------------------------------------------------------
module rocketcpu_param_scheduler
  import rocketcpu_audio_pkg::*;
#(
  parameter int          NPARAMS  = 12,
  parameter logic [31:0] BASE_ADR = 32'h1000_0000
) (
  input  logic                  i_wb_clk,
  input  logic                  i_wb_rst,
  input  logic [31:0]           i_wb_adr,
  input  logic [31:0]           i_wb_dat,
  input  logic [3:0]            i_wb_sel,
  input  logic                  i_wb_we,
  input  logic                  i_wb_cyc,
  output logic [31:0]           o_wb_rdt,
  output logic                  o_wb_ack,
  input  logic                  i_sample_tick,
  output logic [32*NPARAMS-1:0] o_params,
  output logic                  o_commit_pulse,
  output logic                  o_pending
);

  schedState_e state_q, state_d;
  logic [7:0]  commitCount_q, commitCount_d;
  logic        ack_q, ack_d;
  logic [31:0] rdt_q, rdt_d;
  logic        commitPulse_q;

  logic [31:0] offset;
  logic        aligned, isShadow, isLive, isCtrl, isStatus;
  logic        access, ctrlWr, commitReq, abortReq, doCopy;
  logic [31:0] shadowRdata, liveRdata, readData;

  // Address decode. Word windows require an aligned address; anything that
  // falls outside the map reads as zero and swallows writes.
  always_comb begin
    offset   = i_wb_adr - BASE_ADR;
    aligned  = (offset[1:0] == 2'b00);
    isShadow = aligned && (offset[31:7] == SHADOW_OFS[31:7]);
    isLive   = aligned && (offset[31:7] == LIVE_OFS[31:7]);
    isCtrl   = (offset == CTRL_OFS);
    isStatus = (offset == STATUS_OFS);
  end

  // A bus access is taken only while no ack is outstanding, which makes
  // back-to-back requests complete on every other cycle.
  always_comb begin
    access    = i_wb_cyc && !ack_q;
    ctrlWr    = access && i_wb_we && isCtrl;
    commitReq = ctrlWr && i_wb_dat[COMMIT_BIT];
    abortReq  = ctrlWr && i_wb_dat[ABORT_BIT];
  end

  rocketcpu_param_bank #(
    .NPARAMS (NPARAMS)
  ) u_bank (
    .clk_i         (i_wb_clk),
    .rst_i         (i_wb_rst),
    .wrEn_i        (access && i_wb_we && isShadow),
    .wrIdx_i       (offset[6:2]),
    .wrData_i      (i_wb_dat),
    .wrSel_i       (i_wb_sel),
    .copy_i        (doCopy),
    .rdIdx_i       (offset[6:2]),
    .shadowRdata_o (shadowRdata),
    .liveRdata_o   (liveRdata),
    .params_o      (o_params)
  );

  // Commit FSM. In IDLE a commit request arms the scheduler unless an abort
  // is written alongside it. In ARMED a tick always wins: it performs the
  // copy even if an abort arrives on the same cycle. A tick seen in IDLE is
  // simply ignored, so a commit written on a tick cycle waits for the next.
  always_comb begin
    state_d = state_q;
    doCopy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (commitReq && !abortReq) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (i_sample_tick) begin
          doCopy  = 1'b1;
          state_d = IDLE;
        end else if (abortReq) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is taken from the register state before this access, and the
  // commit counter simply wraps at 8 bits.
  always_comb begin
    readData = '0;
    if (isShadow) begin
      readData = shadowRdata;
    end else if (isLive) begin
      readData = liveRdata;
    end else if (isStatus) begin
      readData = {16'h0000, commitCount_q, 7'h00, (state_q == ARMED)};
    end
    ack_d         = access;
    rdt_d         = access ? readData : '0;
    commitCount_d = doCopy ? commitCount_q + 8'd1 : commitCount_q;
  end

  // State, counter and bus response registers. The commit pulse is
  // registered from the same strobe that loads the live bank, so both move
  // together on the output side.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q       <= IDLE;
      commitCount_q <= '0;
      ack_q         <= 1'b0;
      rdt_q         <= '0;
      commitPulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      commitCount_q <= commitCount_d;
      ack_q         <= ack_d;
      rdt_q         <= rdt_d;
      commitPulse_q <= doCopy;
    end
  end

  assign o_wb_ack       = ack_q;
  assign o_wb_rdt       = rdt_q;
  assign o_commit_pulse = commitPulse_q;
  assign o_pending      = (state_q == ARMED);

endmodule

// File: tb/tb_rocketcpu_param_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rocketcpu_param_scheduler
// Directed and randomized bench for the parameter scheduler, checked against
// a register-level reference model of the shadow/live banks, pending flag
// and commit counter.
// ---------------------------------------------------------------------------
module tb_rocketcpu_param_scheduler;

  localparam int          NP    = 12;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] CTRLA = BASE + 32'h100;
  localparam logic [31:0] STATA = BASE + 32'h104;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         adr, dat;
  logic [3:0]          sel;
  logic                we, cyc, tick;
  logic [31:0]         rdt;
  logic                ack, pulse, pending;
  logic [32*NP-1:0]    params;

  int checks = 0;
  int errors = 0;

  logic [31:0] shadowM [NP];
  logic [31:0] liveM   [NP];
  bit          pendingM;
  int          countM;
  bit          pulseM;
  bit          ackM;
  logic [31:0] rdM;
  logic [31:0] lastRd;

  rocketcpu_param_scheduler #(
    .NPARAMS  (NP),
    .BASE_ADR (BASE)
  ) dut (
    .i_wb_clk       (clk),
    .i_wb_rst       (rst),
    .i_wb_adr       (adr),
    .i_wb_dat       (dat),
    .i_wb_sel       (sel),
    .i_wb_we        (we),
    .i_wb_cyc       (cyc),
    .o_wb_rdt       (rdt),
    .o_wb_ack       (ack),
    .i_sample_tick  (tick),
    .o_params       (params),
    .o_commit_pulse (pulse),
    .o_pending      (pending)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  function automatic logic [31:0] shAdr(input int k);
    return BASE + 32'(4 * k);
  endfunction

  function automatic logic [31:0] lvAdr(input int k);
    return BASE + 32'h80 + 32'(4 * k);
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < NP; k++) begin
      shadowM[k] = '0;
      liveM[k]   = '0;
    end
    pendingM = 0;
    countM   = 0;
    pulseM   = 0;
    ackM     = 0;
  endfunction

  // Expected read value: the register map evaluated on the model state
  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [31:0] ofs;
    ofs = a - BASE;
    if (ofs % 4 != 0) return '0;
    if (ofs < 32'h80) return (ofs / 4 < NP) ? shadowM[ofs / 4] : '0;
    if (ofs < 32'h100) return ((ofs - 32'h80) / 4 < NP) ? liveM[(ofs - 32'h80) / 4] : '0;
    if (ofs == 32'h104) return {16'h0, 8'(countM), 7'h0, pendingM};
    return '0;
  endfunction

  // One clock edge of the model: a pending commit plus a tick copies the
  // shadow bank as it stood before any write on the same edge; CTRL writes
  // arm only from idle (abort beats commit) and abort only when no tick.
  function automatic void modelEdge(input bit acc, input logic [31:0] a, d,
                                    input logic [3:0] s, input bit w, input bit t);
    logic [31:0] ofs;
    bit wasPending, commit;
    ofs        = a - BASE;
    wasPending = pendingM;
    commit     = wasPending && t;
    pulseM     = commit;
    if (commit) begin
      for (int k = 0; k < NP; k++) liveM[k] = shadowM[k];
      countM   = (countM + 1) % 256;
      pendingM = 0;
    end
    if (acc && w) begin
      if (ofs < 32'h80 && ofs % 4 == 0 && ofs / 4 < NP) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) shadowM[ofs / 4][8*b +: 8] = d[8*b +: 8];
      end
      if (ofs == 32'h100) begin
        if (!wasPending) pendingM = d[0] && !d[1];
        else if (d[1] && !commit) pendingM = 0;
      end
    end
  endfunction

  // Compare every observable output against the model
  task automatic checkOutput(input string tag);
    logic [32*NP-1:0] expP;
    for (int k = 0; k < NP; k++) expP[32*k +: 32] = liveM[k];
    checks++;
    assert (ack === ackM) else begin
      errors++;
      $error("FAIL %s ack observed=%b expected=%b", tag, ack, ackM);
    end
    if (ackM) begin
      checks++;
      assert (rdt === rdM) else begin
        errors++;
        $error("FAIL %s rdt observed=%h expected=%h", tag, rdt, rdM);
      end
    end
    checks++;
    assert (pending === pendingM) else begin
      errors++;
      $error("FAIL %s pending observed=%b expected=%b", tag, pending, pendingM);
    end
    checks++;
    assert (pulse === pulseM) else begin
      errors++;
      $error("FAIL %s commit_pulse observed=%b expected=%b", tag, pulse, pulseM);
    end
    checks++;
    assert (params === expP) else begin
      errors++;
      $error("FAIL %s params observed=%h expected=%h", tag, params, expP);
    end
  endtask

  // Fixed-value check against a constant taken straight from the test plan
  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expV);
    checks++;
    assert (obs === expV) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expV);
    end
  endtask

  // Drive one clock cycle, then advance and check the model
  task automatic stepEdge(input string tag, input bit acc, input logic [31:0] a, d,
                          input logic [3:0] s, input bit w, input bit t);
    @(negedge clk);
    cyc = acc; adr = a; dat = d; sel = s; we = w; tick = t;
    @(posedge clk);
    #1;
    cyc = 0; we = 0; tick = 0;
    ackM = acc;
    rdM  = modelRead(a);
    modelEdge(acc, a, d, s, w, t);
    if (acc) lastRd = rdt;
    checkOutput(tag);
  endtask

  // One Wishbone access (access cycle + ack cycle), with optional ticks
  task automatic applyStimulus(input string tag, input logic [31:0] a, d,
                               input logic [3:0] s, input bit w, input bit tA, input bit tB);
    stepEdge(tag, 1, a, d, s, w, tA);
    stepEdge(tag, 0, a, d, s, 0, tB);
  endtask

  initial begin
    rst = 1; cyc = 0; adr = '0; dat = '0; sel = '0; we = 0; tick = 0;
    lastRd = '0;
    modelReset();
    #2;
    checkOutput("reset");
    checkValue("resetRdt", rdt, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    applyStimulus("readLive0", lvAdr(0), 0, 4'hF, 0, 0, 0);
    checkValue("live0Zero", lastRd, 32'h0);
    applyStimulus("readStatus", STATA, 0, 4'hF, 0, 0, 0);
    checkValue("statusZero", lastRd, 32'h0);

    applyStimulus("wrShadow0Sel", shAdr(0), 32'hDEAD_BEEF, 4'b0011, 1, 0, 0);
    applyStimulus("rdShadow0", shAdr(0), 0, 4'hF, 0, 0, 0);
    checkValue("shadow0Bytes", lastRd, 32'h0000_BEEF);

    for (int k = 0; k < NP; k++)
      applyStimulus("wrShadowK", shAdr(k), 32'(k + 1), 4'hF, 1, 0, 0);
    applyStimulus("commit", CTRLA, 32'h1, 4'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) stepEdge("waitTick", 0, 0, 0, 0, 0, 0);
    stepEdge("tick", 0, 0, 0, 0, 0, 1);
    checkValue("word11", params[32*11 +: 32], 32'd12);
    stepEdge("pulseEnd", 0, 0, 0, 0, 0, 0);
    applyStimulus("status1", STATA, 0, 4'hF, 0, 0, 0);
    checkValue("statusCount1", lastRd, 32'h0000_0100);

    applyStimulus("commit2", CTRLA, 32'h1, 4'hF, 1, 0, 0);
    applyStimulus("wrShadow3Tick", shAdr(3), 32'h55, 4'hF, 1, 1, 0);
    applyStimulus("rdLive3", lvAdr(3), 0, 4'hF, 0, 0, 0);
    checkValue("live3Old", lastRd, 32'd4);
    applyStimulus("rdShadow3", shAdr(3), 0, 4'hF, 0, 0, 0);
    checkValue("shadow3New", lastRd, 32'h55);

    applyStimulus("commit3", CTRLA, 32'h1, 4'hF, 1, 0, 0);
    applyStimulus("abort", CTRLA, 32'h2, 4'hF, 1, 0, 0);
    stepEdge("tickAfterAbort", 0, 0, 0, 0, 0, 1);
    applyStimulus("commitAbortTogether", CTRLA, 32'h3, 4'hF, 1, 0, 0);
    applyStimulus("commitRepeat", CTRLA, 32'h1, 4'hF, 1, 0, 0);
    applyStimulus("commitWhileArmed", CTRLA, 32'h1, 4'hF, 1, 0, 0);
    applyStimulus("abortWithTick", CTRLA, 32'h2, 4'hF, 1, 1, 0);
    applyStimulus("commitOnIdleTick", CTRLA, 32'h1, 4'hF, 1, 1, 0);
    stepEdge("laterTick", 0, 0, 0, 0, 0, 1);
    applyStimulus("status2", STATA, 0, 4'hF, 0, 0, 0);
    applyStimulus("rdCtrl", CTRLA, 0, 4'hF, 0, 0, 0);
    applyStimulus("rdShadowOOR", shAdr(20), 0, 4'hF, 0, 0, 0);

    for (int n = 0; n < 250; n++) begin
      int          op;
      logic [31:0] a, d;
      op = $urandom_range(0, 6);
      d  = $urandom;
      case (op)
        0: a = shAdr($urandom_range(0, 15));
        1: a = lvAdr($urandom_range(0, 31));
        2: a = CTRLA;
        3: a = STATA;
        4: a = BASE + 32'h200 + 32'($urandom_range(0, 255));
        5: a = shAdr($urandom_range(0, 11)) + 32'($urandom_range(1, 3));
        default: a = shAdr($urandom_range(0, 11));
      endcase
      if (op == 2) d = {30'($urandom), 2'($urandom_range(0, 3))};
      applyStimulus("random", a, d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    applyStimulus("armBeforeReset", CTRLA, 32'h1, 4'hF, 1, 0, 0);
    @(negedge clk);
    rst = 1;
    #1;
    modelReset();
    checkOutput("asyncReset");
    checkValue("asyncResetRdt", rdt, 32'h0);
    @(negedge clk);
    rst = 0;

    for (int n = 0; n < 256; n++) begin
      applyStimulus("wrapCommit", CTRLA, 32'h1, 4'hF, 1, 0, 0);
      stepEdge("wrapTick", 0, 0, 0, 0, 0, 1);
    end
    applyStimulus("statusWrap", STATA, 0, 4'hF, 0, 0, 0);
    checkValue("countWrapped", lastRd, 32'h0);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
